cop0_sequencer: RTL and testbench

COP0_SEQUENCER -- requirements
Module: cop0_sequencer

---
 rtl/cop0_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_cop0_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop0_sequencer.sv
// -----------------------------------------------------------------------------
// cop0_sequencer
//
// Sequences interrupt entry and ERET exit around coprocessor 0 and arbitrates
// the CP0 register port between the CPU (mtc0/mfc0) and the sequencer itself.
//
// Interrupt entry: IDLE -> DRAIN (fetch stalled while in-flight instructions
// retire) -> TAKE (one-cycle entry pulse, flush, redirect to HANDLER_VECTOR).
// ERET exit: IDLE -> ERET_EPC (read EPC) -> ERET_ST (read status) -> ERET_WR
// (write status with bit 0 set, flush, redirect to EPC).
//
// Parameters
//   HANDLER_VECTOR   fetch target on interrupt entry
//   DRAIN_LIMIT      DRAIN cycles after which entry is forced (>= 1)
//
// Ports
//   Clock, Reset          rising-edge clock, synchronous active-high reset
//   Enable                global advance; low freezes every register
//   InterruptRequest      interrupt pending from CP0 (level)
//   CommitValid/CommitPC  retiring instruction and its PC
//   InDelaySlot           retiring instruction sits in a branch delay slot
//   EretCommit            ERET retiring (single-cycle pulse)
//   CpuAddress/CpuDataIn/CpuDataInEnable   CPU side of the CP0 port
//   Cop0DataOut           CP0 read data
//   CpuGrant              CPU owns the CP0 port (CPU stalls mtc0/mfc0 if low)
//   Cop0Address/Cop0DataIn/Cop0DataInEnable   muxed CP0 port
//   InterruptHandled      one-cycle entry pulse to CP0
//   InterruptedPC         restart PC handed to CP0 (holds last value)
//   StallFetch/Flush/FetchRedirect/RedirectPC   pipeline control
//
// Handshake: there is no valid/ready pair here. CpuGrant is a pure ownership
// flag: while it is high the CPU request passes straight through in the same
// cycle; while it is low the CPU must hold its request and the strobe is
// blocked.
//
// Build option
//   COP0_SEQ_DELAY_SLOT_EN  defined: a delay-slot commit during DRAIN enters
//                           TAKE with restart PC = CommitPC - 4 (the branch).
//                           undefined: delay-slot commits never end DRAIN.
// -----------------------------------------------------------------------------
module cop0_sequencer #(
   parameter logic [31:0] HANDLER_VECTOR = 32'h0000_0180,
   parameter int unsigned DRAIN_LIMIT    = 8
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Enable,
   input  logic        InterruptRequest,
   input  logic        CommitValid,
   input  logic [31:0] CommitPC,
   input  logic        InDelaySlot,
   input  logic        EretCommit,
   input  logic [4:0]  CpuAddress,
   input  logic [31:0] CpuDataIn,
   input  logic        CpuDataInEnable,
   input  logic [31:0] Cop0DataOut,
   output logic        CpuGrant,
   output logic [4:0]  Cop0Address,
   output logic [31:0] Cop0DataIn,
   output logic        Cop0DataInEnable,
   output logic        InterruptHandled,
   output logic [31:0] InterruptedPC,
   output logic        StallFetch,
   output logic        Flush,
   output logic        FetchRedirect,
   output logic [31:0] RedirectPC
);

   localparam int unsigned CNT_W = $clog2(DRAIN_LIMIT + 1);

   localparam logic [4:0] EPC_ADDR    = 5'd4;
   localparam logic [4:0] STATUS_ADDR = 5'd12;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DRAIN    = 3'd1,
      TAKE     = 3'd2,
      ERET_EPC = 3'd3,
      ERET_ST  = 3'd4,
      ERET_WR  = 3'd5
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
   logic [31:0]        last_pc_q, last_pc_d;
   logic [31:0]        epc_q, epc_d;
   logic [31:0]        status_q, status_d;
   logic [31:0]        interrupted_pc_q, interrupted_pc_d;
   logic [31:0]        redirect_pc_q, redirect_pc_d;

   // A commit that may end DRAIN, and the restart PC it implies.
   logic               commit_take;
   logic [31:0]        commit_restart_pc;

   always_comb begin
      commit_take       = CommitValid && !InDelaySlot;
      commit_restart_pc = CommitPC;
`ifdef COP0_SEQ_DELAY_SLOT_EN
      // Restart at the branch so it re-executes together with its slot.
      if (CommitValid && InDelaySlot) begin
         commit_take       = 1'b1;
         commit_restart_pc = CommitPC - 32'd4;
      end
`endif
   end

   // Next-state and capture logic. Nothing moves while Enable is low.
   always_comb begin
      state_d          = state_q;
      drain_cnt_d      = drain_cnt_q;
      last_pc_d        = last_pc_q;
      epc_d            = epc_q;
      status_d         = status_q;
      interrupted_pc_d = interrupted_pc_q;
      redirect_pc_d    = redirect_pc_q;

      if (Enable) begin
         if (CommitValid) begin
            last_pc_d = CommitPC;
         end
         drain_cnt_d = '0;

         case (state_q)
            IDLE: begin
               if (EretCommit) begin
                  state_d = ERET_EPC;
               end else if (InterruptRequest) begin
                  state_d = DRAIN;
               end
            end

            DRAIN: begin
               drain_cnt_d = drain_cnt_q + 1'b1;
               if (commit_take) begin
                  state_d          = TAKE;
                  interrupted_pc_d = commit_restart_pc;
                  redirect_pc_d    = HANDLER_VECTOR;
               end else if (!InterruptRequest) begin
                  // Software masked the request while draining: back off.
                  state_d = IDLE;
               end else if (drain_cnt_q == CNT_W'(DRAIN_LIMIT - 1)) begin
                  // Forced entry resumes after the most recent commit, which
                  // may be a delay-slot commit retiring in this very cycle.
                  state_d          = TAKE;
                  interrupted_pc_d = last_pc_d + 32'd4;
                  redirect_pc_d    = HANDLER_VECTOR;
               end
            end

            TAKE: begin
               state_d = IDLE;
            end

            ERET_EPC: begin
               epc_d   = Cop0DataOut;
               state_d = ERET_ST;
            end

            ERET_ST: begin
               status_d      = Cop0DataOut;
               redirect_pc_d = epc_q;
               state_d       = ERET_WR;
            end

            ERET_WR: begin
               state_d = IDLE;
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q          <= IDLE;
         drain_cnt_q      <= '0;
         last_pc_q        <= '0;
         epc_q            <= '0;
         status_q         <= '0;
         interrupted_pc_q <= '0;
         redirect_pc_q    <= '0;
      end else begin
         state_q          <= state_d;
         drain_cnt_q      <= drain_cnt_d;
         last_pc_q        <= last_pc_d;
         epc_q            <= epc_d;
         status_q         <= status_d;
         interrupted_pc_q <= interrupted_pc_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   // Output decode from the registered state. While Reset is high the block
   // presents IDLE with the write strobe blocked, so an abandoned sequence
   // never emits an entry pulse or a CP0 write in the reset cycle.
   state_e out_state;

   always_comb begin
      out_state        = Reset ? IDLE : state_q;
      CpuGrant         = 1'b0;
      Cop0Address      = CpuAddress;
      Cop0DataIn       = CpuDataIn;
      Cop0DataInEnable = 1'b0;
      InterruptHandled = 1'b0;
      StallFetch       = 1'b0;
      Flush            = 1'b0;
      FetchRedirect    = 1'b0;

      case (out_state)
         IDLE: begin
            CpuGrant         = 1'b1;
            Cop0DataInEnable = CpuDataInEnable && !Reset;
         end
         DRAIN: begin
            CpuGrant         = 1'b1;
            Cop0DataInEnable = CpuDataInEnable;
            StallFetch       = 1'b1;
         end
         TAKE: begin
            InterruptHandled = 1'b1;
            Flush            = 1'b1;
            FetchRedirect    = 1'b1;
         end
         ERET_EPC: begin
            Cop0Address = EPC_ADDR;
            StallFetch  = 1'b1;
         end
         ERET_ST: begin
            Cop0Address = STATUS_ADDR;
            StallFetch  = 1'b1;
         end
         ERET_WR: begin
            // Bit 0 set restores the exception-level/enable bit on return.
            Cop0Address      = STATUS_ADDR;
            Cop0DataIn       = status_q | 32'd1;
            Cop0DataInEnable = 1'b1;
            Flush            = 1'b1;
            FetchRedirect    = 1'b1;
         end
         default: begin
            CpuGrant = 1'b0;
         end
      endcase
   end

   assign InterruptedPC = interrupted_pc_q;
   assign RedirectPC    = redirect_pc_q;

endmodule

// File: tb/tb_cop0_sequencer.sv
module tb_cop0_sequencer;

   localparam logic [31:0] HV = 32'h0000_0180;
   localparam int          DL = 8;
   localparam logic [31:0] CD = 32'hAAAA_0003;
   localparam logic [4:0]  CA = 5'd3;
`ifdef COP0_SEQ_DELAY_SLOT_EN
   localparam bit DS_EN = 1'b1;
`else
   localparam bit DS_EN = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst, en, irq, cv, slot, eret, cpu_den;
   logic [31:0] cpc, cpu_din, dout;
   logic [4:0]  cpu_addr;
   logic        grant, den, hnd, stall, flush, fredir;
   logic [4:0]  addr;
   logic [31:0] din, ipc, rpc;

   always #5 clk = ~clk;

   cop0_sequencer #(.HANDLER_VECTOR(HV), .DRAIN_LIMIT(DL)) dut (
      .Clock(clk), .Reset(rst), .Enable(en), .InterruptRequest(irq),
      .CommitValid(cv), .CommitPC(cpc), .InDelaySlot(slot), .EretCommit(eret),
      .CpuAddress(cpu_addr), .CpuDataIn(cpu_din), .CpuDataInEnable(cpu_den),
      .Cop0DataOut(dout), .CpuGrant(grant), .Cop0Address(addr),
      .Cop0DataIn(din), .Cop0DataInEnable(den), .InterruptHandled(hnd),
      .InterruptedPC(ipc), .StallFetch(stall), .Flush(flush),
      .FetchRedirect(fredir), .RedirectPC(rpc)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      rst = 1'b0; en = 1'b1; irq = 1'b0; cv = 1'b0; cpc = '0; slot = 1'b0;
      eret = 1'b0; cpu_addr = CA; cpu_din = CD; cpu_den = 1'b0; dout = '0;
   endtask

   // ---------------- reference model ----------------
   // Sequence position: eret step 0 = none, 1 = reading EPC, 2 = reading
   // status, 3 = writing status; draining with a count of finished cycles;
   // a pending one-cycle entry.
   int          m_eret;
   bit          m_drain, m_take;
   int          m_drain_n;
   logic [31:0] m_last, m_ipc, m_rpc, m_epc, m_status;

   task automatic model_reset();
      m_eret = 0; m_drain = 1'b0; m_take = 1'b0; m_drain_n = 0;
      m_last = '0; m_ipc = '0; m_rpc = '0; m_epc = '0; m_status = '0;
   endtask

   task automatic model_step();
      logic [31:0] newest;
      if (rst) begin
         model_reset();
      end else if (en) begin
         newest = cv ? cpc : m_last;
         if (m_take) begin
            m_take = 1'b0;
         end else if (m_eret == 1) begin
            m_epc = dout; m_eret = 2;
         end else if (m_eret == 2) begin
            m_status = dout; m_rpc = m_epc; m_eret = 3;
         end else if (m_eret == 3) begin
            m_eret = 0;
         end else if (m_drain) begin
            if (cv && (!slot || DS_EN)) begin
               m_ipc = slot ? cpc - 32'd4 : cpc;
               m_rpc = HV; m_take = 1'b1; m_drain = 1'b0;
            end else if (!irq) begin
               m_drain = 1'b0;
            end else if (m_drain_n + 1 == DL) begin
               m_ipc = newest + 32'd4;
               m_rpc = HV; m_take = 1'b1; m_drain = 1'b0;
            end else begin
               m_drain_n++;
            end
         end else if (eret) begin
            m_eret = 1;
         end else if (irq) begin
            m_drain = 1'b1; m_drain_n = 0;
         end
         m_last = newest;
      end
   endtask

   task automatic model_check(input int c);
      logic       e_grant, e_den, e_stall, e_flush, e_hnd;
      logic [4:0] e_addr;
      logic [31:0] e_din;
      if (rst) begin
         e_grant = 1'b1; e_den = 1'b0; e_stall = 1'b0; e_flush = 1'b0;
         e_hnd = 1'b0; e_addr = cpu_addr; e_din = cpu_din;
      end else begin
         e_grant = !(m_take || m_eret != 0);
         e_addr  = (m_eret == 1) ? 5'd4 : (m_eret >= 2) ? 5'd12 : cpu_addr;
         e_din   = (m_eret == 3) ? (m_status | 32'd1) : cpu_din;
         e_den   = (m_eret == 3) || (e_grant && cpu_den);
         e_hnd   = m_take;
         e_flush = m_take || (m_eret == 3);
         e_stall = m_drain || (m_eret == 1) || (m_eret == 2);
      end
      chk($sformatf("rnd%0d.grant", c), grant, e_grant);
      chk($sformatf("rnd%0d.addr", c), addr, e_addr);
      chk($sformatf("rnd%0d.din", c), din, e_din);
      chk($sformatf("rnd%0d.den", c), den, e_den);
      chk($sformatf("rnd%0d.handled", c), hnd, e_hnd);
      chk($sformatf("rnd%0d.stall", c), stall, e_stall);
      chk($sformatf("rnd%0d.flush", c), flush, e_flush);
      chk($sformatf("rnd%0d.fredir", c), fredir, e_flush);
      chk($sformatf("rnd%0d.ipc", c), ipc, m_ipc);
      chk($sformatf("rnd%0d.rpc", c), rpc, m_rpc);
   endtask

   // ---------------- directed sequences ----------------
   task automatic run_timeout(input string tag, input logic [31:0] pc);
      int          n;
      bit          seen;
      logic [31:0] exp_pc;
      exp_pc = pc + 32'd4;
      set_idle(); cv = 1'b1; cpc = pc; tick();
      cv = 1'b0; irq = 1'b1; tick();
      n = 0; seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (hnd) begin
            seen = 1'b1;
            irq  = 1'b0;
            chk({tag, "_ipc"}, ipc, exp_pc);
            chk({tag, "_rpc"}, rpc, HV);
         end else if (stall) begin
            n++;
         end
         @(posedge clk); #1;
      end
      chk({tag, "_entered"}, seen, 1'b1);
      chk({tag, "_drain_cycles"}, n, DL);
      irq = 1'b0; tick();
   endtask

   typedef struct {
      logic        irq, cv;
      logic [31:0] cpc;
      logic        eret;
      logic [31:0] dout;
      logic        grant, stall, flush, hnd, den;
      logic [4:0]  addr;
      logic [31:0] din, ipc, rpc;
   } vec_t;

   vec_t vt[10];

   initial begin
      // IRQ entry with a commit two cycles after the request, then ERET.
      vt[0] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CA,     CD,          32'h0,   32'h0};
      vt[1] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, CA,     CD,          32'h0,   32'h0};
      vt[2] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, CA,     CD,          32'h0,   32'h0};
      vt[3] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, CA,     CD,          32'h100, HV};
      vt[4] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CA,     CD,          32'h100, HV};
      vt[5] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CA,     CD,          32'h100, HV};
      vt[6] = '{1'b0, 1'b1, 32'h500, 1'b0, 32'h200,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4,   CD,          32'h100, HV};
      vt[7] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'hFC00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12,  CD,          32'h100, HV};
      vt[8] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd12,  32'h0000FC01, 32'h100, 32'h200};
      vt[9] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, CA,     CD,          32'h100, 32'h200};

      // Reset state.
      set_idle();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      @(negedge clk);
      chk("rst_grant", grant, 1'b1);
      chk("rst_stall", stall, 1'b0);
      chk("rst_flush", flush, 1'b0);
      chk("rst_handled", hnd, 1'b0);
      chk("rst_den", den, 1'b0);
      chk("rst_ipc", ipc, 32'h0);
      chk("rst_rpc", rpc, 32'h0);
      @(posedge clk); #1;

      // Table-driven entry and ERET sequences.
      cpu_den = 1'b1;
      for (int i = 0; i < 10; i++) begin
         irq = vt[i].irq; cv = vt[i].cv; cpc = vt[i].cpc;
         eret = vt[i].eret; dout = vt[i].dout;
         @(negedge clk);
         chk($sformatf("v%0d.grant", i), grant, vt[i].grant);
         chk($sformatf("v%0d.stall", i), stall, vt[i].stall);
         chk($sformatf("v%0d.flush", i), flush, vt[i].flush);
         chk($sformatf("v%0d.fredir", i), fredir, vt[i].flush);
         chk($sformatf("v%0d.handled", i), hnd, vt[i].hnd);
         chk($sformatf("v%0d.den", i), den, vt[i].den);
         chk($sformatf("v%0d.addr", i), addr, vt[i].addr);
         chk($sformatf("v%0d.din", i), din, vt[i].din);
         chk($sformatf("v%0d.ipc", i), ipc, vt[i].ipc);
         chk($sformatf("v%0d.rpc", i), rpc, vt[i].rpc);
         @(posedge clk); #1;
      end

      // Request masked in the second DRAIN cycle.
      set_idle(); irq = 1'b1; tick();
      @(negedge clk); chk("mask_drain1_stall", stall, 1'b1); @(posedge clk); #1;
      irq = 1'b0;
      @(negedge clk);
      chk("mask_drain2_stall", stall, 1'b1);
      chk("mask_drain2_handled", hnd, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mask_after_stall", stall, 1'b0);
      chk("mask_after_handled", hnd, 1'b0);
      chk("mask_after_grant", grant, 1'b1);
      chk("mask_after_ipc", ipc, 32'h100);
      @(posedge clk); #1;

      // Forced entry after DRAIN_LIMIT cycles, including PC wrap.
      run_timeout("timeout", 32'h40);
      run_timeout("wrap", 32'hFFFF_FFFC);

      // Delay-slot commit during DRAIN.
      set_idle(); irq = 1'b1; tick();
      cv = 1'b1; slot = 1'b1; cpc = 32'h108;
      @(negedge clk); chk("slot_drain_stall", stall, 1'b1); @(posedge clk); #1;
      cv = 1'b0; slot = 1'b0;
      @(negedge clk);
`ifdef COP0_SEQ_DELAY_SLOT_EN
      chk("slot_handled", hnd, 1'b1);
      chk("slot_ipc", ipc, 32'h104);
      irq = 1'b0;
      @(posedge clk); #1;
`else
      chk("slot_still_drain", stall, 1'b1);
      chk("slot_no_handled", hnd, 1'b0);
      cv = 1'b1; cpc = 32'h10C;
      @(posedge clk); #1;
      cv = 1'b0;
      @(negedge clk);
      chk("slot_next_handled", hnd, 1'b1);
      chk("slot_next_ipc", ipc, 32'h10C);
      irq = 1'b0;
      @(posedge clk); #1;
`endif

      // Reset asserted while reading status during ERET.
      set_idle(); eret = 1'b1; tick();
      eret = 1'b0; dout = 32'h300;
      @(negedge clk); chk("eret_rst_epc_addr", addr, 5'd4); @(posedge clk); #1;
      dout = 32'hF0;
      @(negedge clk);
      chk("eret_rst_st_addr", addr, 5'd12);
      rst = 1'b1; #1;
      chk("eret_rst_den_in_reset", den, 1'b0);
      chk("eret_rst_handled_in_reset", hnd, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("eret_rst_after_grant", grant, 1'b1);
      chk("eret_rst_after_stall", stall, 1'b0);
      chk("eret_rst_after_den", den, 1'b0);
      chk("eret_rst_after_flush", flush, 1'b0);
      chk("eret_rst_after_rpc", rpc, 32'h0);
      chk("eret_rst_after_ipc", ipc, 32'h0);
      @(posedge clk); #1;

      // Randomized run against the reference model.
      set_idle(); rst = 1'b1; tick(); rst = 1'b0;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 199) == 0);
         en       = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 7) == 0) irq = ~irq;
         cv       = ($urandom_range(0, 5) == 0);
         cpc      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
         slot     = ($urandom_range(0, 3) == 0);
         eret     = ($urandom_range(0, 19) == 0);
         cpu_addr = 5'($urandom_range(0, 31));
         cpu_din  = $urandom();
         cpu_den  = ($urandom_range(0, 1) == 0);
         dout     = $urandom();
         @(negedge clk);
         model_check(c);
         @(posedge clk);
         model_step();
         #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
